// File: rtl/gru_fxp_pkg.sv
// Fixed-point constants, mode encoding and FSM state type shared by the
// GRU gate-derivative datapath.
package gru_fxp_pkg;

    localparam int FXP_FRAC = 14;
    localparam int FXP_ONE  = 1 << FXP_FRAC;

    typedef enum logic {
        MODE_SIGMOID = 1'b0,
        MODE_TANH    = 1'b1
    } gate_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_SC1  = 3'd2,
        ST_SC2  = 3'd3,
        ST_OUT  = 3'd4
    } gru_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gru_gate_deriv_acc_if.sv
// Operand-beat input stream and single-word result stream of the
// GRU gate-derivative unit.
interface gru_gate_deriv_acc_if #(
    parameter int DATABIT = 16,
    parameter int LANES   = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_mode;
    logic [DATABIT-1:0]         in_gate;
    logic [LANES*DATABIT-1:0]   in_dh;
    logic [LANES*DATABIT-1:0]   in_w;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATABIT-1:0]         out_data;

    modport master (
        output in_valid, in_mode, in_gate, in_dh, in_w, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_gate, in_dh, in_w, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/gru_lane_mac.sv
// LANES-wide signed multiply and adder tree; one sign-extended ACCW sum
// per operand beat.
module gru_lane_mac #(
    parameter int DATABIT = 16,
    parameter int LANES   = 4,
    parameter int ACCW    = 35
) (
    input  logic [LANES*DATABIT-1:0] dh,
    input  logic [LANES*DATABIT-1:0] w,
    output logic signed [ACCW-1:0]   sum
);

    logic signed [ACCW-1:0] dh_ext_s [LANES];
    logic signed [ACCW-1:0] w_ext_s  [LANES];

    // sign-extend each lane before multiplying so the product is exact
    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            dh_ext_s[k] = ACCW'($signed(dh[k*DATABIT +: DATABIT]));
            w_ext_s[k]  = ACCW'($signed(w[k*DATABIT +: DATABIT]));
            sum         = sum + (dh_ext_s[k] * w_ext_s[k]);
        end
    end

endmodule

// File: rtl/gru_gate_deriv_acc.sv
// GRU back-prop gate derivative: out = f'(g) * sum(dh_i * w_i).
// Define GRU_GATE_DERIV_SAT_EN for a saturating result and a sat_flag port.
module gru_gate_deriv_acc
    import gru_fxp_pkg::*;
#(
    parameter int DATABIT = 16,
    parameter int FRAC    = FXP_FRAC,
    parameter int HNUM    = 8,
    parameter int LANES   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gru_gate_deriv_acc_if.slave   bus,
    output logic                  busy
`ifdef GRU_GATE_DERIV_SAT_EN
    ,output logic                 sat_flag
`endif
);

    localparam int BEATS = HNUM / LANES;
    localparam int ONE   = 1 << FRAC;
    localparam int ACCW  = 2*DATABIT + clog2(HNUM);
    localparam int FACW  = 2*DATABIT + 2;
    localparam int RESW  = FACW + ACCW;
    localparam int CNTW  = clog2(BEATS + 1);

    if (HNUM % LANES != 0) begin : g_bad_cfg
        $error("gru_gate_deriv_acc: HNUM must be a multiple of LANES");
    end

    gru_state_e              state_r, state_s;
    logic [CNTW-1:0]         cnt_r, cnt_nxt_s;
    logic signed [ACCW-1:0]  acc_r, beat_sum_s, sum_q_r;
    logic signed [FACW-1:0]  fac_r, fac_s, g_s, one_s;
    logic [DATABIT-1:0]      gate_r, res_red_s, out_data_r;
    gate_mode_e              mode_r;
    logic signed [RESW-1:0]  res_full_s, res_s;
    logic                    in_ready_s, accept_s, first_s, last_s, out_valid_r;

    gru_lane_mac #(.DATABIT(DATABIT), .LANES(LANES), .ACCW(ACCW)) u_mac (
        .dh  (bus.in_dh),
        .w   (bus.in_w),
        .sum (beat_sum_s)
    );

    assign in_ready_s = (state_r == ST_IDLE) || (state_r == ST_ACC);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign first_s    = accept_s && (state_r == ST_IDLE);
    assign cnt_nxt_s  = (state_r == ST_IDLE) ? CNTW'(1) : (cnt_r + CNTW'(1));
    assign last_s     = (cnt_nxt_s == CNTW'(BEATS));

    // next-state sequencing: accumulate beats, two scaling cycles, hold result
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_ACC: begin
                if (accept_s) begin
                    state_s = last_s ? ST_SC1 : ST_ACC;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SC1: state_s = ST_SC2;
            ST_SC2: state_s = ST_OUT;
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // gate factor f'(g) and final rescale of the registered dot product
    always_comb begin
        g_s   = FACW'($signed(gate_r));
        one_s = FACW'(ONE);
        if (mode_r == MODE_TANH) begin
            fac_s = one_s - ((g_s * g_s) >>> FRAC);
        end else begin
            fac_s = (g_s * (one_s - g_s)) >>> FRAC;
        end
        res_full_s = RESW'(fac_r) * RESW'(sum_q_r);
        res_s      = res_full_s >>> FRAC;
    end

`ifdef GRU_GATE_DERIV_SAT_EN
    localparam logic signed [RESW-1:0] RES_MAX = {{(RESW-DATABIT+1){1'b0}}, {(DATABIT-1){1'b1}}};
    localparam logic signed [RESW-1:0] RES_MIN = {{(RESW-DATABIT+1){1'b1}}, {(DATABIT-1){1'b0}}};
    logic sat_s;
    logic sat_flag_r;

    // clamp to the signed DATABIT range and note whether clamping happened
    always_comb begin
        if (res_s > RES_MAX) begin
            res_red_s = {1'b0, {(DATABIT-1){1'b1}}};
            sat_s     = 1'b1;
        end else if (res_s < RES_MIN) begin
            res_red_s = {1'b1, {(DATABIT-1){1'b0}}};
            sat_s     = 1'b1;
        end else begin
            res_red_s = DATABIT'(res_s);
            sat_s     = 1'b0;
        end
    end

    // sticky until the next job starts
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sat_flag_r <= 1'b0;
        end else if (first_s) begin
            sat_flag_r <= 1'b0;
        end else if (state_r == ST_SC2) begin
            sat_flag_r <= sat_s;
        end
    end

    assign sat_flag = sat_flag_r;
`else
    // two's-complement wrap to DATABIT
    always_comb begin
        res_red_s = DATABIT'(res_s);
    end
`endif

    // control state and beat counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                cnt_r <= cnt_nxt_s;
            end
        end
    end

    // datapath: gate latch, accumulation, scaling pipeline, result register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            gate_r      <= '0;
            mode_r      <= MODE_SIGMOID;
            acc_r       <= '0;
            sum_q_r     <= '0;
            fac_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            if (first_s) begin
                gate_r <= bus.in_gate;
                mode_r <= gate_mode_e'(bus.in_mode);
                acc_r  <= beat_sum_s;
            end else if (accept_s) begin
                acc_r  <= acc_r + beat_sum_s;
            end
            if (state_r == ST_SC1) begin
                sum_q_r <= acc_r >>> FRAC;
                fac_r   <= fac_s;
            end
            if (state_r == ST_SC2) begin
                out_data_r  <= res_red_s;
                out_valid_r <= 1'b1;
            end else if ((state_r == ST_OUT) && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_gru_gate_deriv_acc.sv
// Scoreboard bench for gru_gate_deriv_acc (default parameters, ONE = 16384).
module tb_gru_gate_deriv_acc;

    localparam int DATABIT = 16;
    localparam int LANES   = 4;
    localparam int HNUM    = 8;
    localparam int BEATS   = HNUM / LANES;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
`ifdef GRU_GATE_DERIV_SAT_EN
    logic sat_flag;
`endif

    always #5 clk = ~clk;

    gru_gate_deriv_acc_if #(.DATABIT(DATABIT), .LANES(LANES)) bus ();

    gru_gate_deriv_acc #(.DATABIT(DATABIT), .FRAC(14), .HNUM(HNUM), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
`ifdef GRU_GATE_DERIV_SAT_EN
        ,.sat_flag (sat_flag)
`endif
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_rx     = 0;
    int     n_tx     = 0;
    longint exp_q[$];
    int     dh_arr[HNUM];
    int     w_arr[HNUM];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_model(input logic mode, input int g);
        longint s, sq, fac, res;
        logic [15:0] low;
        s = 0;
        for (int i = 0; i < HNUM; i++) s += longint'(dh_arr[i]) * longint'(w_arr[i]);
        sq = s >>> 14;
        if (mode) fac = 16384 - ((longint'(g) * longint'(g)) >>> 14);
        else      fac = (longint'(g) * longint'(16384 - g)) >>> 14;
        res = (fac * sq) >>> 14;
`ifdef GRU_GATE_DERIV_SAT_EN
        if (res > 32767) res = 32767;
        else if (res < -32768) res = -32768;
`else
        low = res[15:0];
        res = longint'($signed(low));
`endif
        return res;
    endfunction

    function automatic longint out_s();
        return longint'($signed(bus.out_data));
    endfunction

    // result scoreboard: compare on the cycle before the handshake edge
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check_val("spurious_out", 1, 0);
            else check_val("out_data", out_s(), exp_q.pop_front());
            n_rx++;
        end
    end

    task automatic fill(input int dh, input int w);
        for (int i = 0; i < HNUM; i++) begin
            dh_arr[i] = dh;
            w_arr[i]  = w;
        end
    endtask

    // called #1 after a rising edge; returns #1 after the accepting edge
    task automatic drive_beat(input int b, input logic mode, input int gate);
        int t;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_gate  = 16'(gate);
        for (int k = 0; k < LANES; k++) begin
            bus.in_dh[k*DATABIT +: DATABIT] = 16'(dh_arr[b*LANES + k]);
            bus.in_w[k*DATABIT +: DATABIT]  = 16'(w_arr[b*LANES + k]);
        end
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check_val("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // later beats carry a different mode/gate, which must be ignored
    task automatic run_job(input logic mode, input int g, input int gap, input longint expv);
        for (int b = 0; b < BEATS; b++) begin
            if (b == BEATS - 1) begin
                exp_q.push_back(expv);
                n_tx++;
            end
            if (b == 0) drive_beat(b, mode, g);
            else        drive_beat(b, ~mode, g ^ 16'h3A5C);
            check_val("busy_in_job", busy, 1);
            if (b < BEATS - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        check_val("lat_edge0_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        check_val("lat_edge1_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        check_val("lat_edge2_valid", bus.out_valid, 1);
        check_val("lat_edge2_busy", busy, 1);
        if (bus.out_ready) begin
            @(posedge clk); #1;
            check_val("post_hs_valid", bus.out_valid, 0);
            check_val("post_hs_busy", busy, 0);
            check_val("post_hs_ready", bus.in_ready, 1);
        end
    endtask

    initial begin
        int g, t;
        logic m;
        longint ev;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_gate   = '0;
        bus.in_dh     = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_data", out_s(), 0);
        check_val("rst_busy", busy, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("rst_in_ready", bus.in_ready, 1);

        // sigmoid and tanh with identical operands
        fill(16384, 2048);
        run_job(1'b0, 8192, 0, 4096);
`ifdef GRU_GATE_DERIV_SAT_EN
        check_val("sat_flag_clear", sat_flag, 0);
`endif
        run_job(1'b1, 8192, 0, 12288);

        // negative sum with idle gaps between beats
        fill(-16384, 2048);
        run_job(1'b0, 8192, 3, -4096);

        // out-of-range result
        fill(32767, 32767);
`ifdef GRU_GATE_DERIV_SAT_EN
        run_job(1'b1, 8192, 0, 32767);
        check_val("sat_flag_set", sat_flag, 1);
`else
        run_job(1'b1, 8192, 0, -24);
`endif

        // back-pressure with a new job already waiting
        fill(16384, 2048);
        bus.out_ready = 1'b0;
        run_job(1'b0, 8192, 0, 4096);
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check_val("stall_valid", bus.out_valid, 1);
            check_val("stall_data", out_s(), 4096);
            check_val("stall_in_ready", bus.in_ready, 0);
        end
`ifdef GRU_GATE_DERIV_SAT_EN
        check_val("sat_flag_cleared", sat_flag, 0);
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("release_valid", bus.out_valid, 0);
        check_val("release_in_ready", bus.in_ready, 1);
        check_val("release_busy", busy, 0);
        run_job(1'b1, 8192, 0, 12288);

        // reset in the middle of a job leaves no residue
        fill(-16384, 2048);
        drive_beat(0, 1'b1, 8192);
        rst_n = 1'b1;
        #1;
        check_val("midrst_valid", bus.out_valid, 0);
        check_val("midrst_data", out_s(), 0);
        check_val("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        fill(16384, 2048);
        run_job(1'b0, 8192, 0, 4096);

        // random operands against the reference model
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < HNUM; i++) begin
                dh_arr[i] = int'($urandom_range(6000)) - 3000;
                w_arr[i]  = int'($urandom_range(6000)) - 3000;
            end
            g  = int'($urandom_range(16384));
            m  = 1'($urandom_range(1));
            ev = ref_model(m, g);
            run_job(m, g, j, ev);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("queue_drained", exp_q.size(), 0);
        check_val("result_count", n_rx, n_tx);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
